// File: rtl/pi_plot_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : pi_plot_renderer_if
// Description : Point-write handshake between the estimator core and the
//               plot renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pi_plot_renderer_if;
    logic       pt_valid;
    logic       pt_ready;
    logic [7:0] pt_x;
    logic [7:0] pt_y;
    logic       pt_in;

    modport master (
        output pt_valid,
        output pt_x,
        output pt_y,
        output pt_in,
        input  pt_ready
    );

    modport slave (
        input  pt_valid,
        input  pt_x,
        input  pt_y,
        input  pt_in,
        output pt_ready
    );
endinterface
`default_nettype wire

// File: rtl/pi_plot_renderer.sv
`default_nettype none
// ============================================================================
// Module      : pi_plot_renderer
// Description : 256x256 Monte-Carlo plot memory with border, rendered to
//               12-bit VGA RGB with a fixed two-cycle video pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_plot_renderer #(
    parameter int unsigned X0           = 192,
    parameter int unsigned Y0           = 112,
    parameter logic [11:0] COLOR_IN     = 12'h0F0,
    parameter logic [11:0] COLOR_OUT    = 12'hF00,
    parameter logic [11:0] COLOR_BORDER = 12'hFFF,
    parameter logic [11:0] COLOR_BG     = 12'h000
) (
    input  wire logic         clk25,
    input  wire logic         rst,
    input  wire logic [9:0]   px_x,
    input  wire logic [9:0]   px_y,
    input  wire logic         vidSel,
    input  wire logic         HS,
    input  wire logic         VS,
    pi_plot_renderer_if.slave pt,
    input  wire logic         clear_start,
    output logic              busy,
    output logic [15:0]       pt_count,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs
);

    localparam logic [9:0]  c_x_lo   = 10'(X0);
    localparam logic [9:0]  c_x_end  = 10'(X0 + 256);
    localparam logic [9:0]  c_x_bl   = 10'(X0 - 1);
    localparam logic [9:0]  c_y_lo   = 10'(Y0);
    localparam logic [9:0]  c_y_end  = 10'(Y0 + 256);
    localparam logic [9:0]  c_y_bl   = 10'(Y0 - 1);
    localparam logic [1:0]  c_code_in  = 2'b01;
    localparam logic [1:0]  c_code_out = 2'b10;
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    typedef enum logic [0:0] {
        S_CLEAR  = 1'b0,
        S_ACCEPT = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] clr_addr_q;
    logic [15:0] pt_count_q;
    logic        pt_ready_q;
    logic        busy_q;

    logic        w_accept;
    logic        w_mem_we;
    logic [15:0] w_mem_waddr;
    logic [1:0]  w_mem_wdata;

    logic [1:0]  mem_q [0:65535];

    // ------------------------------------------------------------------
    // Control FSM: sweep-clear, then accept point writes
    // ------------------------------------------------------------------
    assign w_accept = (state_q == S_ACCEPT) && pt.pt_valid && pt_ready_q;

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= 16'd0;
            pt_count_q <= 16'd0;
            pt_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    pt_count_q <= 16'd0;
                    clr_addr_q <= clr_addr_q + 16'd1;
                    if (clr_addr_q == 16'hFFFF) begin
                        state_q    <= S_ACCEPT;
                        pt_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (w_accept && (pt_count_q != c_cnt_max)) begin
                        pt_count_q <= pt_count_q + 16'd1;
                    end
                    // A point accepted alongside clear_start still lands and counts
                    if (clear_start) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= 16'd0;
                        pt_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_CLEAR;
                    clr_addr_q <= 16'd0;
                    pt_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = clr_addr_q;
        w_mem_wdata = 2'b00;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                w_mem_we = 1'b1;
            end else if (w_accept) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = {pt.pt_y, pt.pt_x};
                w_mem_wdata = pt.pt_in ? c_code_in : c_code_out;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign pt.pt_ready = pt_ready_q;
    assign busy        = busy_q;
    assign pt_count    = pt_count_q;

    // ------------------------------------------------------------------
    // Video stage 1: pixel classification and registered read address
    // ------------------------------------------------------------------
    logic        w_in_x;
    logic        w_in_y;
    logic        w_span_x;
    logic        w_span_y;
    logic        w_win;
    logic        w_border;
    logic [15:0] w_rd_addr;

    assign w_in_x   = (px_x >= c_x_lo) && (px_x <  c_x_end);
    assign w_in_y   = (px_y >= c_y_lo) && (px_y <  c_y_end);
    assign w_span_x = (px_x >= c_x_bl) && (px_x <= c_x_end);
    assign w_span_y = (px_y >= c_y_bl) && (px_y <= c_y_end);
    assign w_win    = w_in_x && w_in_y;
    assign w_border = (((px_x == c_x_bl) || (px_x == c_x_end)) && w_span_y) ||
                      (((px_y == c_y_bl) || (px_y == c_y_end)) && w_span_x);
    assign w_rd_addr = {8'(px_y - c_y_lo), 8'(px_x - c_x_lo)};

    logic [15:0] rd_addr_q;
    logic        win_q;
    logic        border_q;
    logic        vid_q;
    logic        hs_q;
    logic        vs_q;

    always_ff @(posedge clk25) begin
        if (rst) begin
            rd_addr_q <= 16'd0;
            win_q     <= 1'b0;
            border_q  <= 1'b0;
            vid_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            rd_addr_q <= w_rd_addr;
            win_q     <= w_win;
            border_q  <= w_border;
            vid_q     <= vidSel;
            hs_q      <= HS;
            vs_q      <= VS;
        end
    end

    // ------------------------------------------------------------------
    // Video stage 2: colour select from the addressed cell
    // ------------------------------------------------------------------
    logic [1:0]  w_cell;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        vga_hs_q;
    logic        vga_vs_q;

    // The read address is the RAM's registered address, so the cell arrives
    // in stage 2 and a same-cycle write to that cell is seen on the next read.
    assign w_cell = mem_q[rd_addr_q];

    always_comb begin
        rgb_d = COLOR_BG;
        if (!vid_q) begin
            rgb_d = 12'h000;
        end else if (win_q) begin
            if (w_cell == c_code_in) begin
                rgb_d = COLOR_IN;
            end else if (w_cell == c_code_out) begin
                rgb_d = COLOR_OUT;
            end
        end else if (border_q) begin
            rgb_d = COLOR_BORDER;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            rgb_q    <= 12'h000;
            vga_hs_q <= 1'b1;
            vga_vs_q <= 1'b1;
        end else begin
            rgb_q    <= rgb_d;
            vga_hs_q <= hs_q;
            vga_vs_q <= vs_q;
        end
    end

    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_plot_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi_plot_renderer
// Description : Self-checking bench for pi_plot_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_plot_renderer;

    localparam int X0 = 192;
    localparam int Y0 = 112;

    logic        clk25 = 1'b0;
    logic        rst;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        vidSel;
    logic        HS;
    logic        VS;
    logic        clear_start;
    wire         busy;
    wire  [15:0] pt_count;
    wire  [3:0]  vga_r;
    wire  [3:0]  vga_g;
    wire  [3:0]  vga_b;
    wire         vga_hs;
    wire         vga_vs;

    pi_plot_renderer_if pif ();

    pi_plot_renderer dut (
        .clk25       (clk25),
        .rst         (rst),
        .px_x        (px_x),
        .px_y        (px_y),
        .vidSel      (vidSel),
        .HS          (HS),
        .VS          (VS),
        .pt          (pif),
        .clear_start (clear_start),
        .busy        (busy),
        .pt_count    (pt_count),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    always #20 clk25 = ~clk25;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  model [0:65535];
    int unsigned mcount;

    typedef struct {
        int          x;
        int          y;
        bit          v;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 65536; i++) model[i] = 2'b00;
        mcount = 0;
    endfunction

    function automatic void model_write(input logic [7:0] x, input logic [7:0] y, input bit in);
        model[{y, x}] = in ? 2'b01 : 2'b10;
        if (mcount < 65535) mcount++;
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit v);
        int cx;
        int cy;
        if (!v) return 12'h000;
        cx = x - X0;
        cy = y - Y0;
        if (cx >= 0 && cx < 256 && cy >= 0 && cy < 256) begin
            case (model[cy * 256 + cx])
                2'b01:   return 12'h0F0;
                2'b10:   return 12'hF00;
                default: return 12'h000;
            endcase
        end
        if ((cx == -1 || cx == 256) && cy >= -1 && cy <= 256) return 12'hFFF;
        if ((cy == -1 || cy == 256) && cx >= -1 && cx <= 256) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic drive_px(input int x, input int y, input bit v, input bit hs, input bit vs);
        px_x   = 10'(x);
        px_y   = 10'(y);
        vidSel = v;
        HS     = hs;
        VS     = vs;
    endtask

    task automatic apply_vec(input vec_t e, input string name);
        drive_px(e.x, e.y, e.v, e.hs, e.vs);
        tick();
        tick();
        check(name, {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, e.rgb, e.hs, e.vs});
    endtask

    task automatic put_point(input logic [7:0] x, input logic [7:0] y, input bit in);
        bit done;
        done = 1'b0;
        pif.pt_valid = 1'b1;
        pif.pt_x     = x;
        pif.pt_y     = y;
        pif.pt_in    = in;
        for (int w = 0; w < 70000 && !done; w++) begin
            if (pif.pt_ready === 1'b1) begin
                tick();
                model_write(x, y, in);
                done = 1'b1;
            end else begin
                tick();
            end
        end
        pif.pt_valid = 1'b0;
        if (!done) check("point handshake timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_video(input int n, input bool_window, input string name);
    endtask

    task automatic rand_stream(input int n, input bit window_only, input string name);
        logic [13:0] q [$];
        logic [13:0] e;
        int x, y;
        bit v, hs, vs;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 3) != 0) || window_only;
            if (v) begin
                if (window_only || $urandom_range(0, 1) == 1) begin
                    x = window_only ? $urandom_range(X0, X0 + 255) : $urandom_range(X0 - 7, X0 + 263);
                    y = window_only ? $urandom_range(Y0, Y0 + 255) : $urandom_range(Y0 - 7, Y0 + 263);
                end else begin
                    x = $urandom_range(0, 639);
                    y = $urandom_range(0, 479);
                end
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            drive_px(x, y, v, hs, vs);
            q.push_back({exp_rgb(x, y, v), hs, vs});
            tick();
            if (q.size() == 2) begin
                e = q.pop_front();
                check(name, {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, e});
            end
        end
    endtask

    initial begin
        #(40 * 260000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ready_bad;
        logic [7:0] rx, ry;
        bit  rin;

        rst          = 1'b1;
        clear_start  = 1'b0;
        pif.pt_valid = 1'b0;
        pif.pt_x     = 8'd0;
        pif.pt_y     = 8'd0;
        pif.pt_in    = 1'b0;
        drive_px(0, 0, 0, 1, 1);
        model_clear();

        // Reset state
        repeat (3) tick();
        check("reset video outputs", {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, 12'h000, 2'b11});
        check("reset busy", {31'd0, busy}, 32'd1);
        check("reset pt_ready", {31'd0, pif.pt_ready}, 32'd0);
        check("reset pt_count", {16'd0, pt_count}, 32'd0);

        // Reset in the middle of a sweep restarts it
        rst = 1'b0;
        repeat (1000) tick();
        check("busy early in sweep", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Sweep length; points and clear_start offered during it are ignored
        n = 0;
        ready_bad = 1'b0;
        while (busy === 1'b1 && n < 70000) begin
            if (pif.pt_ready !== 1'b0) ready_bad = 1'b1;
            pif.pt_valid = 1'b1;
            pif.pt_x     = 8'($urandom);
            pif.pt_y     = 8'($urandom);
            pif.pt_in    = 1'($urandom);
            clear_start  = (n == 20000);
            n++;
            tick();
        end
        clear_start  = 1'b0;
        pif.pt_valid = 1'b0;
        check("initial busy length", 32'(n), 32'd65536);
        check("pt_ready low while busy", {31'd0, ready_bad}, 32'd0);
        check("busy after sweep", {31'd0, busy}, 32'd0);
        check("pt_ready after sweep", {31'd0, pif.pt_ready}, 32'd1);
        check("count after sweep", {16'd0, pt_count}, 32'd0);

        // Plot two corner cells and check classification table
        put_point(8'd0, 8'd0, 1'b1);
        put_point(8'd255, 8'd255, 1'b0);
        check("pt_count after two points", {16'd0, pt_count}, 32'd2);

        vecs[0]  = '{192, 112, 1'b1, 1'b1, 1'b1, 12'h0F0};
        vecs[1]  = '{447, 367, 1'b1, 1'b1, 1'b1, 12'hF00};
        vecs[2]  = '{191, 112, 1'b1, 1'b1, 1'b1, 12'hFFF};
        vecs[3]  = '{448, 200, 1'b1, 1'b1, 1'b1, 12'hFFF};
        vecs[4]  = '{100, 100, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[5]  = '{191, 111, 1'b1, 1'b0, 1'b1, 12'hFFF};
        vecs[6]  = '{448, 368, 1'b1, 1'b1, 1'b0, 12'hFFF};
        vecs[7]  = '{300, 111, 1'b1, 1'b1, 1'b1, 12'hFFF};
        vecs[8]  = '{300, 368, 1'b1, 1'b0, 1'b0, 12'hFFF};
        vecs[9]  = '{449, 200, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[10] = '{190, 200, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[11] = '{300, 369, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[12] = '{193, 112, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[13] = '{192, 112, 1'b0, 1'b0, 1'b1, 12'h000};
        vecs[14] = '{1000, 1000, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[15] = '{640, 112, 1'b0, 1'b1, 1'b1, 12'h000};
        for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("pixel vector %0d", i));

        // Latency: exactly two cycles, not one
        drive_px(0, 0, 0, 1, 1);
        tick();
        tick();
        drive_px(192, 112, 1, 0, 1);
        tick();
        drive_px(0, 0, 0, 1, 1);
        check("latency t+1 not yet", {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, 12'h000, 2'b11});
        tick();
        check("latency t+2", {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, 12'h0F0, 2'b01});

        // Back-to-back overwrite of one cell
        pif.pt_valid = 1'b1;
        pif.pt_x = 8'd10; pif.pt_y = 8'd20; pif.pt_in = 1'b1;
        check("ready for overwrite", {31'd0, pif.pt_ready}, 32'd1);
        tick();
        model_write(8'd10, 8'd20, 1'b1);
        pif.pt_in = 1'b0;
        tick();
        model_write(8'd10, 8'd20, 1'b0);
        pif.pt_valid = 1'b0;
        apply_vec('{202, 132, 1'b1, 1'b1, 1'b1, 12'hF00}, "overwritten cell");
        check("pt_count after overwrite", {16'd0, pt_count}, 32'd4);

        // Random plot against the model
        for (int i = 0; i < 200; i++) put_point(8'($urandom_range(0, 63)), 8'($urandom_range(0, 63)), 1'($urandom));
        check("pt_count after random points", {16'd0, pt_count}, 32'(mcount));
        rand_stream(3000, 1'b0, "random video");

        // Clear requested together with an accepted point
        for (int i = 0; i < 10; i++) put_point(8'($urandom), 8'($urandom), 1'($urandom));
        rx = 8'($urandom); ry = 8'($urandom); rin = 1'($urandom);
        pif.pt_valid = 1'b1;
        pif.pt_x = rx; pif.pt_y = ry; pif.pt_in = rin;
        check("ready before clear", {31'd0, pif.pt_ready}, 32'd1);
        clear_start = 1'b1;
        tick();
        model_write(rx, ry, rin);
        clear_start = 1'b0;
        check("count includes point with clear", {16'd0, pt_count}, 32'(mcount));
        check("busy on clear", {31'd0, busy}, 32'd1);
        check("ready drops on clear", {31'd0, pif.pt_ready}, 32'd0);
        model_clear();

        n = 0;
        ready_bad = 1'b0;
        while (busy === 1'b1 && n < 70000) begin
            if (n == 1) check("count zeroed in clear", {16'd0, pt_count}, 32'd0);
            if (pif.pt_ready !== 1'b0) ready_bad = 1'b1;
            pif.pt_valid = 1'b1;
            pif.pt_x     = 8'($urandom);
            pif.pt_y     = 8'($urandom);
            pif.pt_in    = 1'($urandom);
            clear_start  = (n == 30000);
            n++;
            tick();
        end
        clear_start  = 1'b0;
        pif.pt_valid = 1'b0;
        check("clear busy length", 32'(n), 32'd65536);
        check("pt_ready low during clear", {31'd0, ready_bad}, 32'd0);
        check("ready after clear", {31'd0, pif.pt_ready}, 32'd1);
        check("count after clear", {16'd0, pt_count}, 32'd0);
        apply_vec('{192, 112, 1'b1, 1'b1, 1'b1, 12'h000}, "cleared cell 0,0");
        apply_vec('{202, 132, 1'b1, 1'b1, 1'b1, 12'h000}, "cleared cell 10,20");
        apply_vec('{448, 368, 1'b1, 1'b1, 1'b1, 12'hFFF}, "border survives clear");
        rand_stream(2000, 1'b1, "cleared window");

        // Saturation: continuous accepts past 65535
        ready_bad = 1'b0;
        pif.pt_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); rin = 1'($urandom);
            pif.pt_x = rx; pif.pt_y = ry; pif.pt_in = rin;
            if (pif.pt_ready !== 1'b1) ready_bad = 1'b1;
            tick();
            model_write(rx, ry, rin);
        end
        pif.pt_valid = 1'b0;
        check("ready during saturation run", {31'd0, ready_bad}, 32'd0);
        check("pt_count saturated", {16'd0, pt_count}, 32'd65535);
        rand_stream(1500, 1'b0, "video after saturation");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pi_plot_renderer.md
# pi_plot_renderer

Downstream consumer of the VGA timing generator. Keeps a 256x256 two-bit-per-cell plot memory of Monte-Carlo sample points (inside/outside the quarter circle) and a one-pixel border around it. Converts the timing generator's pixel coordinates and sync/blank signals into registered 12-bit RGB plus aligned HS/VS for the Cora VGA Pmod. Point writes arrive from the estimator core over a valid/ready handshake.

## Interface
- X0, 192, left column of plot window in active-pixel coordinates
- Y0, 112, top row of plot window
- COLOR_IN, 12'h0F0, colour of cell marked inside
- COLOR_OUT, 12'hF00, colour of cell marked outside
- COLOR_BORDER, 12'hFFF, border colour
- COLOR_BG, 12'h000, colour of every other active pixel
- clk25  in  1  pixel clock, the only clock
- rst  in  1  synchronous, active-high reset
- px_x  in  10  active-area column from timing generator
- px_y  in  10  active-area row from timing generator
- vidSel  in  1  active-video flag from timing generator
- HS  in  1  horizontal sync from timing generator (low during pulse)
- VS  in  1  vertical sync from timing generator (low during pulse)
- pt_valid  in  1  point write request
- pt_ready  out  1  point write accepted when high with pt_valid
- pt_x  in  8  cell column 0..255
- pt_y  in  8  cell row 0..255
- pt_in  in  1  1 = inside circle, 0 = outside
- clear_start  in  1  one-cycle request to erase the plot
- busy  out  1  high while clearing
- pt_count  out  16  points accepted since last clear, saturates at 65535
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hs, vga_vs  out  1 each  delayed syncs

## Operation
- Memory: 65536 x 2 bits, address {pt_y, pt_x}. Codes: 00 empty, 01 inside, 10 outside; 11 never written. Write port is owned by the control FSM. Read port is owned by video, synchronous read. Simultaneous read/write of one address returns old data.
- FSM states: CLEAR and ACCEPT.
  - rst forces CLEAR with clear address 0.
  - CLEAR writes 00 to one address per cycle, 0 up to 65535, then goes to ACCEPT. Duration is 65536 cycles.
  - In ACCEPT, clear_start enters CLEAR at address 0. clear_start during CLEAR is ignored; the sweep does not restart.
  - rst mid-clear restarts the sweep at address 0.
- pt_ready is registered. It is 1 only in ACCEPT and drops in the first cycle of CLEAR. busy equals (state == CLEAR).
- In ACCEPT, pt_valid & pt_ready writes {0, pt_in} ? 01 : 10 to the addressed cell, overwriting any earlier value. pt_count then increments unless it is at 65535.
- If clear_start and an accepted point occur in the same cycle, the point is written and counted. CLEAR starts on the next cycle.
- Entry into CLEAR zeroes pt_count.
- Pixel classification, using px coordinates and the parameters:
  - Window: X0 <= px_x < X0+256 and Y0 <= px_y < Y0+256. Shows memory cell (px_y-Y0, px_x-X0): 01 gives COLOR_IN, 10 gives COLOR_OUT, 00 and 11 give COLOR_BG.
  - Border: one-pixel ring just outside the window, columns X0-1 and X0+256 and rows Y0-1 and Y0+256, spanning X0-1..X0+256. Shows COLOR_BORDER.
  - Everything else while active shows COLOR_BG.
  - Delayed vidSel = 0 forces RGB 000.
- Arithmetic: offsets are computed in 10-bit unsigned. The window test uses full 10-bit compares, not truncated offsets. px values outside 0..639 / 0..479 while vidSel = 0 must not affect the output.

## Timing
- Video latency is exactly 2 clk25 cycles. vga_r/g/b, vga_hs and vga_vs in cycle t+2 reflect px_x, px_y, vidSel, HS and VS sampled in cycle t.
- Stage 1 registers the read address (driven into memory), window/border flags, vidSel, HS and VS.
- Stage 2 registers the colour and the syncs.
- Syncs and colour stay aligned; there is no extra delay on either.
- Reset values: vga_r/g/b 0, vga_hs 1, vga_vs 1, pipeline vidSel 0, pipeline syncs 1, pt_count 0, busy 1, pt_ready 0.
- After rst is released, busy stays high for 65536 cycles. pt_ready rises in the cycle busy falls.
- A point accepted in cycle t appears on screen in the first frame scanning that cell with read at cycle > t.

## Test plan
- Reset: hold rst 3 cycles then release -> busy = 1 and pt_ready = 0 for 65536 cycles, then busy = 0 and pt_ready = 1. Outputs are 0/1/1 during reset.
- Plot: write (x=0,y=0,in=1) and (255,255,0), then scan a frame -> pixel (192,112) = 0F0, (447,367) = F00, (191,112) = FFF, (448,200) = FFF, (100,100) = 000, and pt_count = 2.
- Latency: drive px_x=192, px_y=112, vidSel=1, HS=0 at cycle t -> RGB 0F0 and vga_hs = 0 appear at t+2, not earlier. vidSel = 0 -> RGB 000.
- Handshake/overwrite: hold pt_valid with pt_ready toggled by clear_start. Write the same cell with in=1 then in=0 -> cell shows F00. Points offered during busy are not counted.
- Clear mid-run: accept 10 points, pulse clear_start together with an 11th point -> pt_count reads 11 for one cycle, then 0. After the sweep, all window pixels = 000. A clear_start during the sweep does not extend busy beyond 65536 cycles.
- Saturation: accept 65537 points -> pt_count holds 65535.
